// File: rtl/bcci_axis_pkg.sv
// bcci_axis_pkg: types and width helpers shared by the framer and its skid buffer
package bcci_axis_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
   typedef struct packed {
      logic user;
      logic last;
   } beat_tag_t;
   localparam int TAG_W = $bits(beat_tag_t);
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bcci_axis_skid.sv
// bcci_axis_skid: two-entry valid/ready skid buffer with a registered output beat
module bcci_axis_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data,
   output logic [1:0]   occ
);
   logic [1:0] occ_q, occ_d;
   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic push, pop;
   assign s_ready = occ_q != 2'd2;
   assign m_valid = occ_q != 2'd0;
   assign m_data  = head_q;
   assign occ     = occ_q;
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;
   // head is the beat on the output; tail only fills while head is stalled
   always_comb begin
      occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
      head_d = head_q;
      tail_d = tail_q;
      if (push && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) head_d = s_data;
      else if (push) tail_d = s_data;
      else if (pop && occ_q == 2'd2) head_d = tail_q;
   end
   // storage and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end
endmodule

// File: rtl/bcci_axis_framer.sv
// bcci_axis_framer: frames a raw pixel stream into AXI4-Stream with SOF on tuser and EOL on tlast
module bcci_axis_framer
   import bcci_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int IMG_WIDTH  = 960,
   parameter int IMG_HEIGHT = 540,
   parameter int ID_VALUE   = 0,
   parameter int DEST_VALUE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    busy,
   output logic                    frame_done,
   input  logic                    pix_valid,
   output logic                    pix_ready,
   input  logic [DATA_WIDTH-1:0]   pix_data,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tid,
   output logic                    m_axis_tdest
);
   localparam int XW = cnt_w(IMG_WIDTH);
   localparam int YW = cnt_w(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      beat_tag_t             tag;
   } beat_t;
   state_t state_q, state_d;
   logic [XW-1:0] in_x_q, in_x_d;
   logic [YW-1:0] in_y_q, in_y_d;
   logic done_q, done_d;
   logic skid_ready, accept, pop_final, x_last, y_last;
   logic [1:0] occ;
   beat_t in_beat, out_beat;
   assign x_last    = in_x_q == X_LAST;
   assign y_last    = in_y_q == Y_LAST;
   assign pix_ready = (state_q == ST_RUN) && skid_ready;
   assign accept    = pix_valid && pix_ready;
   assign in_beat   = {pix_data, (in_x_q == '0) && (in_y_q == '0), x_last};
   // no beats enter during DRAIN, so the final beat is the only one left when occupancy is 1
   assign pop_final = m_axis_tvalid && m_axis_tready && occ == 2'd1;
   bcci_axis_skid #(.W(DATA_WIDTH + TAG_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (accept),
      .s_ready (skid_ready),
      .s_data  (in_beat),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready),
      .m_data  (out_beat),
      .occ     (occ)
   );
   // frame sequencing and raster position of the next accepted pixel
   always_comb begin
      state_d = state_q;
      in_x_d  = in_x_q;
      in_y_d  = in_y_q;
      done_d  = 1'b0;
      if (state_q == ST_IDLE && start) begin
         state_d = ST_RUN;
         in_x_d  = '0;
         in_y_d  = '0;
      end else if (accept) begin
         in_x_d  = x_last ? '0 : in_x_q + 1'b1;
         in_y_d  = x_last ? (y_last ? '0 : in_y_q + 1'b1) : in_y_q;
         state_d = (x_last && y_last) ? ST_DRAIN : ST_RUN;
      end else if (state_q == ST_DRAIN && pop_final) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
      end
   end
   // state, counters and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         in_x_q  <= '0;
         in_y_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         in_x_q  <= in_x_d;
         in_y_q  <= in_y_d;
         done_q  <= done_d;
      end
   end
   assign busy         = state_q != ST_IDLE;
   assign frame_done   = done_q;
   assign m_axis_tdata = out_beat.data;
   assign m_axis_tuser = out_beat.tag.user;
   assign m_axis_tlast = out_beat.tag.last;
   assign m_axis_tkeep = '1;
   assign m_axis_tstrb = '1;
   assign m_axis_tid   = 1'(ID_VALUE);
   assign m_axis_tdest = 1'(DEST_VALUE);
endmodule
